// File: rtl/alu_op_sequencer_if.sv
// Command/result handshake bundle for alu_op_sequencer.
// ALU_SEQ_FLAGS_EN adds res_zero/res_parity to the result side.
interface alu_op_sequencer_if #(
  parameter int N = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic [2:0]   res_op;
  logic         res_illegal;
`ifdef ALU_SEQ_FLAGS_EN
  logic         res_zero;
  logic         res_parity;
`endif

  modport master (
`ifdef ALU_SEQ_FLAGS_EN
    input  res_zero,
    input  res_parity,
`endif
    output cmd_valid,
    input  cmd_ready,
    output cmd_op,
    output cmd_a,
    output cmd_b,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_op,
    input  res_illegal
  );

  modport slave (
`ifdef ALU_SEQ_FLAGS_EN
    output res_zero,
    output res_parity,
`endif
    input  cmd_valid,
    output cmd_ready,
    input  cmd_op,
    input  cmd_a,
    input  cmd_b,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_op,
    output res_illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command front end for the logic-unit mux: drive, settle, capture, hand off.
// ALU_SEQ_FLAGS_EN enables res_zero/res_parity result flags.
module alu_op_sequencer #(
  parameter int N      = 8,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_op_sequencer_if.slave bus,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_s,
  input  logic [N-1:0] alu_out
);

  localparam int CW = $clog2(SETTLE + 1);

  if (SETTLE < 1 || SETTLE > 15 || N < 2) begin : g_bad_cfg
    $error("alu_op_sequencer: illegal N/SETTLE");
  end

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESULT
  } state_t;

  state_t        state;
  logic          live;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic          ill_q;
  logic          cmd_ill;
  logic          accept;

  // live holds cmd_ready low until the first edge after reset release
  assign bus.cmd_ready = live & (state == IDLE);
  assign cmd_ill       = bus.cmd_op[2] & bus.cmd_op[1];
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      live            <= 1'b0;
      cnt             <= '0;
      op_q            <= 3'b000;
      ill_q           <= 1'b0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_s           <= 3'b000;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_op      <= 3'b000;
      bus.res_illegal <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      bus.res_zero    <= 1'b0;
      bus.res_parity  <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a <= bus.cmd_a;
            alu_b <= bus.cmd_b;
            alu_s <= cmd_ill ? 3'b000 : bus.cmd_op;
            op_q  <= bus.cmd_op;
            ill_q <= cmd_ill;
            cnt   <= CW'(SETTLE - 1);
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            bus.res_data    <= alu_out;
            bus.res_op      <= op_q;
            bus.res_illegal <= ill_q;
`ifdef ALU_SEQ_FLAGS_EN
            bus.res_zero    <= (alu_out == '0);
            bus.res_parity  <= ^alu_out;
`endif
            bus.res_valid   <= 1'b1;
            state           <= RESULT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.res_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + random checks of alu_op_sequencer (SETTLE=2 main, SETTLE=1 rate).
// Build with ALU_SEQ_FLAGS_EN to also check res_zero/res_parity.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_f(logic [2:0] s, logic [7:0] a, logic [7:0] b);
    case (s)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a & b);
      3'b100:  return ~(a | b);
      3'b101:  return ~(a ^ b);
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic [7:0] ref_res(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    return alu_f((op > 3'd5) ? 3'd0 : op, a, b);
  endfunction

  alu_op_sequencer_if #(.N(8)) c0 ();
  alu_op_sequencer_if #(.N(8)) c1 ();
  logic [7:0] a0, b0, o0, a1, b1, o1;
  logic [2:0] s0, s1;

  assign o0 = alu_f(s0, a0, b0);
  assign o1 = alu_f(s1, a1, b1);

  alu_op_sequencer #(.N(8), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(c0),
    .alu_a(a0), .alu_b(b0), .alu_s(s0), .alu_out(o0)
  );

  alu_op_sequencer #(.N(8), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(c1),
    .alu_a(a1), .alu_b(b1), .alu_s(s1), .alu_out(o1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!c0.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_timeout", c0.cmd_ready, 1'b1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int hold);
    logic [7:0] exp;
    int lat;
    exp = ref_res(op, a, b);
    wait_ready();
    c0.cmd_valid = 1'b1;
    c0.cmd_op    = op;
    c0.cmd_a     = a;
    c0.cmd_b     = b;
    tick();
    c0.cmd_valid = 1'b0;
    chk("alu_a", a0, a);
    chk("alu_b", b0, b);
    chk("alu_s", s0, (op > 3'd5) ? 3'd0 : op);
    chk("busy_ready", c0.cmd_ready, 1'b0);
    lat = 0;
    while (!c0.res_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, 2);
    chk("res_data", c0.res_data, exp);
    chk("res_op", c0.res_op, op);
    chk("res_illegal", c0.res_illegal, (op > 3'd5));
`ifdef ALU_SEQ_FLAGS_EN
    chk("res_zero", c0.res_zero, (exp == 8'h00));
    chk("res_parity", c0.res_parity, ^exp);
`endif
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", c0.res_valid, 1'b1);
      chk("hold_data", c0.res_data, exp);
      chk("hold_alu_a", a0, a);
    end
    c0.res_ready = 1'b1;
    tick();
    c0.res_ready = 1'b0;
    chk("valid_drop", c0.res_valid, 1'b0);
    chk("ready_back", c0.cmd_ready, 1'b1);
  endtask

  initial begin
    logic [2:0] rop;
    logic [7:0] ra, rb;
    logic [7:0] q_exp[$];
    int last_t, nres, t, acc;
    c0.cmd_valid = 1'b0; c0.cmd_op = '0; c0.cmd_a = '0; c0.cmd_b = '0;
    c0.res_ready = 1'b0;
    c1.cmd_valid = 1'b0; c1.cmd_op = '0; c1.cmd_a = '0; c1.cmd_b = '0;
    c1.res_ready = 1'b0;

    repeat (3) tick();
    chk("rst_ready", c0.cmd_ready, 1'b0);
    chk("rst_valid", c0.res_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("init_ready", c0.cmd_ready, 1'b1);
    chk("init_valid", c0.res_valid, 1'b0);
    chk("init_alu_s", s0, 3'b000);
    chk("init_alu_a", a0, 8'h00);
    chk("init_res", {c0.res_data, c0.res_op, c0.res_illegal}, 12'h000);

    run_op(3'b001, 8'hF0, 8'h0F, 0);

    wait_ready();
    c0.cmd_valid = 1'b1; c0.cmd_op = 3'b010;
    c0.cmd_a = 8'hAA; c0.cmd_b = 8'hAA;
    tick();
    c0.cmd_valid = 1'b1; c0.cmd_op = 3'b000;
    c0.cmd_a = 8'h12; c0.cmd_b = 8'h34;
    tick(); tick();
    chk("x_valid", c0.res_valid, 1'b1);
    chk("x_data", c0.res_data, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("x_ignored_ready", c0.cmd_ready, 1'b0);
      chk("x_ignored_alu_a", a0, 8'hAA);
      chk("x_hold", c0.res_data, 8'h00);
    end
    c0.res_ready = 1'b1;
    tick();
    c0.res_ready = 1'b0;
    chk("x_ready_back", c0.cmd_ready, 1'b1);
    tick();
    c0.cmd_valid = 1'b0;
    chk("x_late_accept", a0, 8'h12);
    tick(); tick();
    chk("x_late_res", c0.res_data, 8'h12 & 8'h34);
    c0.res_ready = 1'b1;
    tick();
    c0.res_ready = 1'b0;

    run_op(3'b111, 8'h3C, 8'h0F, 1);
    run_op(3'b000, 8'h55, 8'hAA, 0);

    wait_ready();
    c0.cmd_valid = 1'b1; c0.cmd_op = 3'b001;
    c0.cmd_a = 8'h81; c0.cmd_b = 8'h18;
    tick();
    c0.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", c0.res_valid, 1'b0);
    chk("mid_rst_alu", {a0, b0, s0}, 19'h0);
    chk("mid_rst_ready", c0.cmd_ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", c0.res_valid, 1'b0);
    end
    chk("post_rst_ready", c0.cmd_ready, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      run_op(rop, ra, rb, int'($urandom_range(0, 3)));
    end

    c1.res_ready = 1'b1;
    c1.cmd_valid = 1'b1;
    c1.cmd_op = 3'($urandom_range(0, 5));
    c1.cmd_a = 8'($urandom);
    c1.cmd_b = 8'($urandom);
    nres = 0;
    last_t = -1;
    acc = 0;
    for (t = 0; t < 30; t++) begin
      if (c1.cmd_valid && c1.cmd_ready) begin
        q_exp.push_back(ref_res(c1.cmd_op, c1.cmd_a, c1.cmd_b));
        acc++;
      end
      tick();
      if (q_exp.size() > 0 && c1.cmd_valid && a1 == c1.cmd_a && !c1.cmd_ready
          && acc > nres && s1 == c1.cmd_op) begin
        if (acc < 5) begin
          c1.cmd_op = 3'($urandom_range(0, 5));
          c1.cmd_a = 8'($urandom);
          c1.cmd_b = 8'($urandom);
        end else begin
          c1.cmd_valid = 1'b0;
        end
      end
      if (c1.res_valid) begin
        chk("s1_data", c1.res_data, q_exp.pop_front());
        if (last_t >= 0) chk("s1_period", t - last_t, 3);
        last_t = t;
        nres++;
      end
    end
    c1.cmd_valid = 1'b0;
    chk("s1_count", nres, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
